// File: rtl/tt_um_josebpswks_uart_tx.sv
// UART transmitter for a TinyTapeout tile.
// Frame: start bit (0), 8 data bits LSB first, optional even-parity bit, stop bit (1).
// Optional feature: define UART_TX_PARITY_EN to insert the even-parity bit (11-bit frame);
// without it the frame is 10 bits and the parity state is never entered.
// uo_out = {frame_count[4:0], tx_ready, busy, txd}; uio_in[0] = tx_valid.

module tt_um_josebpswks_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    localparam logic [7:0] LastCnt = 8'(CLKS_PER_BIT - 1);

    state_t     state_q;
    logic       txd_q;
    logic       busy_q;
    logic       tx_ready_q;
    logic [4:0] frame_cnt_q;
    logic [7:0] bit_cnt_q;
    logic [2:0] data_idx_q;
    logic [7:0] data_q;

    logic tx_valid;
    logic bit_end;
    logic unused_uio;

    assign tx_valid   = uio_in[0];
    assign unused_uio = ^uio_in[7:1];
    assign bit_end    = (bit_cnt_q == LastCnt);

    // Single-process FSM: every visible output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            frame_cnt_q <= 5'd0;
            bit_cnt_q   <= 8'd0;
            data_idx_q  <= 3'd0;
            data_q      <= 8'h00;
        end else begin
            // Bit-period counter runs in every non-idle state and wraps at the bit boundary.
            if (state_q != StIdle) begin
                bit_cnt_q <= bit_end ? 8'd0 : bit_cnt_q + 8'd1;
            end

            case (state_q)
                StIdle: begin
                    txd_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    bit_cnt_q <= 8'd0;
                    if (tx_ready_q && tx_valid) begin
                        state_q    <= StStart;
                        data_q     <= ui_in;
                        txd_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        tx_ready_q <= 1'b0;
                    end else begin
                        tx_ready_q <= ena;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q <= StData;
                        txd_q   <= data_q[0];
                    end
                end
                StData: begin
                    if (bit_end) begin
                        data_idx_q <= data_idx_q + 3'd1;
                        if (data_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= StParity;
                            txd_q   <= ^data_q;
`else
                            state_q <= StStop;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            txd_q <= data_q[data_idx_q + 3'd1];
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop;
                        txd_q   <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        tx_ready_q  <= ena;
                        frame_cnt_q <= frame_cnt_q + 5'd1;
                        txd_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    txd_q      <= 1'b1;
                    busy_q     <= 1'b0;
                    tx_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out  = {frame_cnt_q, tx_ready_q, busy_q, txd_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_josebpswks_uart_tx.sv
// Directed bench for the UART transmitter with CLKS_PER_BIT = 4.

module tb_tt_um_josebpswks_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FLEN = 11;
`else
    localparam int FLEN = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic       tx_valid;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // Upper uio bits carry a fixed pattern the design must ignore.
    assign uio_in = {7'b1010101, tx_valid};

    tt_um_josebpswks_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    always #5 clk = ~clk;

    // seq holds start, d0..d7, stop in transmission order, first bit at the MSB.
    typedef struct {
        logic [7:0] data;
        logic [9:0] seq;
        logic       par;
    } vec_t;

    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int b);
        if (b < 9) return v.seq[9 - b];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return v.par;
`endif
        return 1'b1;
    endfunction

    // Wait (bounded) for tx_ready, then present a byte; returns at the negedge after accept.
    task automatic start_frame(input logic [7:0] d);
        int n = 0;
        while (uo_out[2] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 32'(uo_out[2]), 32'd1);
        ui_in    = d;
        tx_valid = 1'b1;
        @(negedge clk);
    endtask

    // mode 0: plain, 1: keep tx_valid high, 2: mid-frame data change + valid pulse,
    // 3: drop ena mid-frame.
    task automatic run_frame(input vec_t v, input int mode);
        int   busy_cnt = 0;
        logic bad;
        for (int b = 0; b < FLEN; b++) begin
            bad = 1'b0;
            for (int c = 0; c < CPB; c++) begin
                int k = b * CPB + c;
                if (mode != 1 && k == 0) tx_valid = 1'b0;
                if (mode == 2 && k == 10) begin
                    ui_in    = ~v.data;
                    tx_valid = 1'b1;
                end
                if (mode == 2 && k == 11) tx_valid = 1'b0;
                if (mode == 3 && k == 5) ena = 1'b0;
                if (uo_out[0] !== exp_bit(v, b)) bad = 1'b1;
                if (uo_out[2] !== 1'b0) bad = 1'b1;
                if (uo_out[1] === 1'b1) busy_cnt++;
                @(negedge clk);
            end
            chk($sformatf("txd_bit%0d_d%02h", b, v.data), 32'(bad), 32'd0);
        end
        exp_cnt = (exp_cnt + 1) % 32;
        chk($sformatf("busy_len_d%02h", v.data), busy_cnt, FLEN * CPB);
        chk("busy_after", 32'(uo_out[1]), 32'd0);
        chk("txd_idle", 32'(uo_out[0]), 32'd1);
        chk("frame_cnt", 32'(uo_out[7:3]), 32'(exp_cnt));
        chk("ready_after", 32'(uo_out[2]), (mode == 3) ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic bad;
        vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
        vecs[1] = '{8'h07, 10'b0111000001, 1'b1};
        vecs[2] = '{8'h3C, 10'b0001111001, 1'b0};
        vecs[3] = '{8'hC3, 10'b0110000111, 1'b0};
        vecs[4] = '{8'h01, 10'b0100000001, 1'b1};
        vecs[5] = '{8'hFF, 10'b0111111111, 1'b0};
        vecs[6] = '{8'h00, 10'b0000000001, 1'b0};

        rst_n    = 1'b0;
        ena      = 1'b1;
        tx_valid = 1'b0;
        ui_in    = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(uo_out[0]), 32'd1);
        chk("rst_busy", 32'(uo_out[1]), 32'd0);
        chk("rst_ready", 32'(uo_out[2]), 32'd0);
        chk("rst_cnt", 32'(uo_out[7:3]), 32'd0);
        chk("uio_out", 32'(uio_out), 32'd0);
        chk("uio_oe", 32'(uio_oe), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_first_edge", 32'(uo_out[2]), 32'd1);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            start_frame(vecs[i].data);
            run_frame(vecs[i], 0);
        end

        // Mid-frame data change and valid pulse: no effect, no extra frame.
        start_frame(vecs[0].data);
        run_frame(vecs[0], 2);
        bad = 1'b0;
        repeat (8) begin
            if (uo_out[1] !== 1'b0 || uo_out[0] !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        chk("no_extra_frame", 32'(bad), 32'd0);

        // ena drops mid-frame: frame finishes, no readiness until ena returns.
        start_frame(vecs[2].data);
        run_frame(vecs[2], 3);
        ena = 1'b1;
        @(negedge clk);
        chk("ready_after_ena", 32'(uo_out[2]), 32'd1);

        // tx_valid held high across two frames: second accept 41 cycles after first.
        start_frame(vecs[2].data);
        run_frame(vecs[2], 1);
        ui_in = vecs[3].data;
        @(negedge clk);
        run_frame(vecs[3], 0);

        // Reset in the middle of a frame, then ena low with tx_valid high.
        start_frame(vecs[0].data);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_txd", 32'(uo_out[0]), 32'd1);
        chk("async_rst_busy", 32'(uo_out[1]), 32'd0);
        chk("async_rst_cnt", 32'(uo_out[7:3]), 32'd0);
        exp_cnt  = 0;
        ena      = 1'b0;
        tx_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bad   = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b1 || uo_out[1] !== 1'b0 || uo_out[2] !== 1'b0) bad = 1'b1;
        end
        chk("ena_low_no_accept", 32'(bad), 32'd0);
        ena      = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(uo_out[2]), 32'd1);

        // 32 frames: counter wraps back to zero.
        for (int i = 0; i < 32; i++) begin
            start_frame(vecs[i % 7].data);
            run_frame(vecs[i % 7], 0);
        end
        chk("cnt_wrapped", 32'(uo_out[7:3]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
